// File: rtl/mw_add_seq.sv
// Multi-word add sequencer: splits two wide operands into WIDTH-bit chunks,
// feeds them LSW first to an external combinational adder, ripples the carry
// through a register between chunks, and presents the assembled result with
// a valid/ready handshake.
module mw_add_seq #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_cin,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout,
  output logic                   busy
);

  localparam int TW = WIDTH * WORDS;
  // Keep the chunk index at least one bit wide so WORDS=1 still elaborates.
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic          carry;
  logic [TW-1:0] a_reg;
  logic [TW-1:0] b_reg;
  logic [TW-1:0] sum_reg;
  logic [TW-1:0] sum_nxt;

  // Handshake and status flags decode directly from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, walk all chunks in RUN, wait for consumer in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = RUN;
        else          state_nxt = IDLE;
      end
      RUN: begin
        if (idx == LAST_IDX) state_nxt = DONE;
        else                 state_nxt = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
        else           state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Partial sum with the current adder chunk merged in at the active index.
  always_comb begin
    sum_nxt = sum_reg;
    sum_nxt[idx*WIDTH +: WIDTH] = add_sum;
  end

  // Adder drive: the selected operand chunks during RUN, quiet zeros otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[idx*WIDTH +: WIDTH];
      add_b   = b_reg[idx*WIDTH +: WIDTH];
      add_cin = carry;
    end else begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
    end
  end

  // Datapath: operand capture, per-chunk sum/carry collection, result publish.
  // out_sum/out_cout are separate so the previous result survives the next RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg <= sum_nxt;
          carry   <= add_cout;
          if (idx == LAST_IDX) begin
            out_sum  <= sum_nxt;
            out_cout <= add_cout;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mw_add_seq.sv
// Bench for mw_add_seq: a 4x4-bit instance and a 1x8-bit instance, each wired
// to a behavioural ripple adder; results compared with whole-operand arithmetic.
module tb_mw_add_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Instance 0: WIDTH=4, WORDS=4
  logic        in_valid0, in_ready0, in_cin0, out_valid0, out_ready0, out_cout0, busy0;
  logic [15:0] in_a0, in_b0, out_sum0;
  logic [3:0]  add_a0, add_b0, add_sum0;
  logic        add_cin0, add_cout0;
  assign {add_cout0, add_sum0} = 5'(add_a0) + 5'(add_b0) + 5'(add_cin0);

  mw_add_seq #(.WIDTH(4), .WORDS(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a0), .in_b(in_b0), .in_cin(in_cin0),
    .add_a(add_a0), .add_b(add_b0), .add_cin(add_cin0),
    .add_sum(add_sum0), .add_cout(add_cout0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_sum(out_sum0), .out_cout(out_cout0), .busy(busy0)
  );

  // Instance 1: WIDTH=8, WORDS=1
  logic       in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1, busy1;
  logic [7:0] in_a1, in_b1, out_sum1, add_a1, add_b1, add_sum1;
  logic       add_cin1, add_cout1;
  assign {add_cout1, add_sum1} = 9'(add_a1) + 9'(add_b1) + 9'(add_cin1);

  mw_add_seq #(.WIDTH(8), .WORDS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: carry into chunk k of a 4-bit-chunked add is bit 4k of the
  // sum of the low 4k bits of both operands plus cin.
  function automatic logic carry_into(input logic [15:0] a, b, input logic c, input int k);
    logic [16:0] m, s;
    m = (17'd1 << (4 * k)) - 17'd1;
    s = (17'(a) & m) + (17'(b) & m) + 17'(c);
    return s[4*k];
  endfunction

  // One full transaction on instance 0, with optional in_valid glitch during
  // RUN and a number of DONE cycles with out_ready held low.
  task automatic do_add0(input logic [15:0] a, b, input logic c, input int hold, input bit glitch);
    logic [16:0] exp;
    exp = 17'(a) + 17'(b) + 17'(c);
    @(negedge clk);
    chk("idle_in_ready", in_ready0, 1'b1);
    in_valid0 = 1'b1; in_a0 = a; in_b0 = b; in_cin0 = c;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid0 = 1'b0;
      if (glitch && k == 1) begin
        in_valid0 = 1'b1; in_a0 = 16'($urandom); in_b0 = 16'($urandom); in_cin0 = 1'($urandom);
      end
      chk("run_out_valid", out_valid0, 1'b0);
      chk("run_in_ready", in_ready0, 1'b0);
      chk("run_add_cin", add_cin0, carry_into(a, b, c, k));
      chk("run_add_a", add_a0, 4'((a >> (4 * k)) & 16'hF));
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    chk("latency_out_valid", out_valid0, 1'b1);
    chk("done_sum", out_sum0, exp[15:0]);
    chk("done_cout", out_cout0, exp[16]);
    chk("done_busy", busy0, 1'b1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid0, 1'b1);
      chk("hold_sum", out_sum0, exp[15:0]);
      chk("hold_cout", out_cout0, exp[16]);
      chk("hold_in_ready", in_ready0, 1'b0);
    end
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
    chk("post_hs_valid", out_valid0, 1'b0);
    chk("post_hs_in_ready", in_ready0, 1'b1);
    chk("post_hs_retain", out_sum0, exp[15:0]);
    chk("post_hs_drive0", {add_a0, add_b0, add_cin0}, 9'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid0 = 1'b0; in_a0 = '0; in_b0 = '0; in_cin0 = 1'b0; out_ready0 = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0; out_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_out_sum", out_sum0, 16'h0000);
    chk("rst_out_cout", out_cout0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_drive", {add_a0, add_b0, add_cin0}, 9'd0);

    // Directed cases
    do_add0(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    do_add0(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
    do_add0(16'hA5A5, 16'h5A5B, 1'b0, 5, 1'b0);
    do_add0(16'h0F0F, 16'h0101, 1'b0, 1, 1'b1);

    // Reset in RUN at idx=2
    @(negedge clk);
    in_valid0 = 1'b1; in_a0 = 16'h7777; in_b0 = 16'h8888; in_cin0 = 1'b1;
    @(negedge clk); in_valid0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_add_a_idx2", add_a0, 4'h7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready0, 1'b1);
    chk("midrst_out_valid", out_valid0, 1'b0);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_drive", {add_a0, add_b0, add_cin0}, 9'd0);
    chk("midrst_out_sum", out_sum0, 16'h0000);
    do_add0(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 20; n++)
      do_add0(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

    // WORDS=1 instance
    @(negedge clk);
    in_valid1 = 1'b1; in_a1 = 8'hF0; in_b1 = 8'h20; in_cin1 = 1'b0;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("w1_run_valid", out_valid1, 1'b0);
    chk("w1_run_add_a", add_a1, 8'hF0);
    @(negedge clk);
    chk("w1_out_valid", out_valid1, 1'b1);
    chk("w1_out_sum", out_sum1, 8'h10);
    chk("w1_out_cout", out_cout1, 1'b1);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("w1_idle", in_ready1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
